// File: rtl/fft_pkg.sv
// Shared types and sizing for the FFT serial-to-beat packer.
// Optional feature macro used by fft_beat_packer: FFT_PACKER_ABORT_EN.
package fft_pkg;

  localparam int SAMPLE_W  = 34;
  localparam int LANES     = 4;
  localparam int FRAME_LEN = 16;
  localparam int FRAME_GAP = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [LANES-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } packer_state_t;

endpackage

// File: rtl/fft_lane_shifter.sv
// Holds the first LANES-1 samples of a beat; the final lane is taken straight
// from the input so the full beat is available in the cycle lane 3 arrives.
module fft_lane_shifter
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load,
  input  logic [SAMPLE_W-1:0]         sample_in,
  output logic [LANES*SAMPLE_W-1:0]   beat
);

  sample_t [LANES-2:0] held;

  // New samples enter at the top; after LANES-1 loads lane 0 sits at the bottom.
  // Clear together with load restarts the beat with this sample as lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (load) begin
      held[LANES-2] <= sample_in;
      for (int i = 0; i < LANES-2; i++) begin
        held[i] <= clear ? '0 : held[i+1];
      end
    end else if (clear) begin
      held <= '0;
    end
  end

  assign beat = {sample_in, held};

endmodule

// File: rtl/fft_beat_packer.sv
// Packs serial complex samples into LANES-wide beats, 4 beats per frame,
// then holds off input for FRAME_GAP cycles. Macro: FFT_PACKER_ABORT_EN.
module fft_beat_packer
  import fft_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SAMPLE_W-1:0]       sample_in,
  input  logic                      sample_valid,
  input  logic                      frame_start,
  output logic                      sample_ready,
  output logic [LANES*SAMPLE_W-1:0] data_out,
  output logic                      data_out_flag,
  output logic                      frame_done
`ifdef FFT_PACKER_ABORT_EN
  ,
  output logic                      frame_abort
`endif
);

  localparam int LANE_W = $clog2(LANES);
  localparam int GAP_W  = $clog2(FRAME_GAP);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES-1);
  localparam logic [LANE_W-1:0] BEAT_LAST = LANE_W'(FRAME_LEN/LANES-1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP-1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [LANE_W-1:0] lane_cnt;
  logic [LANE_W-1:0] beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              accept;
  logic              start_accept;
  logic              shift_load;
  logic [LANES*SAMPLE_W-1:0] beat;

  assign sample_ready = ~rst & (state != ST_DRAIN);
  assign accept       = sample_valid & sample_ready;
  assign start_accept = accept & frame_start;

  // The lane-3 sample bypasses the shifter; every other accepted sample of a
  // frame (including an aborting frame_start) is shifted in.
  assign shift_load = start_accept |
                      (accept & (state == ST_FILL) & (lane_cnt != LANE_LAST));

  fft_lane_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_accept),
    .load      (shift_load),
    .sample_in (sample_in),
    .beat      (beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lane_cnt      <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      data_out      <= '0;
      data_out_flag <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      data_out_flag <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_accept) begin
            state    <= ST_FILL;
            lane_cnt <= LANE_W'(1);
            beat_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (start_accept) begin
            lane_cnt <= LANE_W'(1);
            beat_cnt <= '0;
          end else if (accept) begin
            lane_cnt <= lane_cnt + LANE_W'(1);
            if (lane_cnt == LANE_LAST) begin
              data_out      <= beat;
              data_out_flag <= 1'b1;
              beat_cnt      <= beat_cnt + LANE_W'(1);
              if (beat_cnt == BEAT_LAST) begin
                frame_done <= 1'b1;
                state      <= ST_DRAIN;
                gap_cnt    <= '0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FFT_PACKER_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_abort <= 1'b0;
    end else if (start_accept && state == ST_FILL) begin
      frame_abort <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_beat_packer.sv
// Self-checking bench for fft_beat_packer: directed scenarios plus random frames
// against a queue-based frame model. Works with or without FFT_PACKER_ABORT_EN.
module tb_fft_beat_packer;
  import fft_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SAMPLE_W-1:0]       sample_in;
  logic                      sample_valid;
  logic                      frame_start;
  logic                      sample_ready;
  logic [LANES*SAMPLE_W-1:0] data_out;
  logic                      data_out_flag;
  logic                      frame_done;
`ifdef FFT_PACKER_ABORT_EN
  logic                      frame_abort;
`endif

  fft_beat_packer dut (
    .clk           (clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .frame_start   (frame_start),
    .sample_ready  (sample_ready),
    .data_out      (data_out),
    .data_out_flag (data_out_flag),
    .frame_done    (frame_done)
`ifdef FFT_PACKER_ABORT_EN
    ,
    .frame_abort   (frame_abort)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the samples of the frame in progress, plus expected outputs.
  sample_t                   cur[$];
  bit                        in_frame;
  int                        drain_left;
  logic [LANES*SAMPLE_W-1:0] exp_data;
  logic                      exp_flag;
  logic                      exp_done;
  logic                      exp_abort;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [LANES*SAMPLE_W-1:0] obs,
                            input logic [LANES*SAMPLE_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_bit({tag, "/flag"}, data_out_flag, exp_flag);
    check_bit({tag, "/done"}, frame_done, exp_done);
    check_word({tag, "/data"}, data_out, exp_data);
`ifdef FFT_PACKER_ABORT_EN
    check_bit({tag, "/abort"}, frame_abort, exp_abort);
`endif
  endtask

  task automatic model_reset();
    cur.delete();
    in_frame   = 0;
    drain_left = 0;
    exp_data   = '0;
    exp_flag   = 1'b0;
    exp_done   = 1'b0;
    exp_abort  = 1'b0;
  endtask

  task automatic model_accept(input logic fs, input sample_t d);
    int base;
    if (!in_frame) begin
      if (fs) begin
        cur.delete();
        cur.push_back(d);
        in_frame = 1;
      end
    end else if (fs) begin
      exp_abort = 1'b1;
      cur.delete();
      cur.push_back(d);
    end else begin
      cur.push_back(d);
      if (cur.size() % LANES == 0) begin
        base = cur.size() - LANES;
        for (int j = 0; j < LANES; j++) exp_data[SAMPLE_W*j +: SAMPLE_W] = cur[base+j];
        exp_flag = 1'b1;
        if (cur.size() == FRAME_LEN) begin
          exp_done   = 1'b1;
          in_frame   = 0;
          drain_left = FRAME_GAP;
          cur.delete();
        end
      end
    end
  endtask

  // Called at a falling edge: drive one cycle of input, check ready, clock it in,
  // then check the registered outputs at the next falling edge.
  task automatic apply_stimulus(input logic v, input logic fs, input sample_t d, input string tag);
    bit exp_ready;
    sample_valid = v;
    frame_start  = fs;
    sample_in    = d;
    #1;
    exp_ready = (drain_left == 0);
    check_bit({tag, "/ready"}, sample_ready, exp_ready);
    if (!exp_ready) drain_left--;
    exp_flag = 1'b0;
    exp_done = 1'b0;
    if (v && exp_ready) model_accept(fs, d);
    @(posedge clk);
    @(negedge clk);
    check_output(tag);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_bit({tag, "/ready"}, sample_ready, 1'b0);
    check_output(tag);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    sample_in    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input sample_t base, input int bubble_mode, input string tag);
    for (int k = 0; k < FRAME_LEN; k++) begin
      apply_stimulus(1'b1, k == 0, base + sample_t'(k), tag);
      if (bubble_mode == 1) apply_stimulus(1'b0, 1'b0, '0, tag);
    end
  endtask

  task automatic idle_cycles(input int n, input logic v, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(v, 1'b0, sample_t'(32'hAA00 + i), tag);
  endtask

  function automatic sample_t rand_sample();
    return sample_t'({$urandom(), $urandom()});
  endfunction

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    sample_in    = '0;
    model_reset();
    @(negedge clk);

    $display("[TB] reset and basic frame");
    reset_dut("reset");
    send_frame(sample_t'(0), 0, "t1");

    $display("[TB] drain gap with offered samples");
    idle_cycles(FRAME_GAP + 2, 1'b1, "t2");

    $display("[TB] frame with bubbles");
    send_frame(sample_t'(0), 1, "t3");
    idle_cycles(FRAME_GAP + 1, 1'b0, "t3gap");

    $display("[TB] samples without frame_start in idle");
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, sample_t'(32'h20 + i), "t4drop");
    send_frame(sample_t'(32'h40), 0, "t4");
    idle_cycles(FRAME_GAP + 1, 1'b0, "t4gap");

    $display("[TB] abort mid frame");
    for (int k = 0; k < 6; k++) apply_stimulus(1'b1, k == 0, sample_t'(32'h60 + k), "t5a");
    send_frame(sample_t'(32'h80), 0, "t5");
    idle_cycles(FRAME_GAP + 1, 1'b0, "t5gap");

    $display("[TB] reset mid frame");
    for (int k = 0; k < 10; k++) apply_stimulus(1'b1, k == 0, sample_t'(32'h100 + k), "t6a");
    reset_dut("t6rst");
    send_frame(sample_t'(32'h200), 0, "t6");
    idle_cycles(FRAME_GAP + 1, 1'b0, "t6gap");

    $display("[TB] random traffic");
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 60; c++) begin
        logic v;
        logic fs;
        v  = ($urandom_range(0, 3) != 0);
        fs = (c == 0) || ($urandom_range(0, 40) == 0);
        apply_stimulus(v | (c == 0), fs, rand_sample(), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
